ed25519_sign_s_sched: RTL and testbench
=======================================

Name: ed25519_sign_s_sched

Overview:
- Front-end controller for the Ed25519 signature S-core wrapper.
- Assembles the three 512-bit digests (key, r/ram, sm) from a 64-bit streaming bus into holding registers.
- Launches the S-core with a one-cycle enable when the core reports ready, then waits for completion with a watchdog.
- Captures the 256-bit S value and returns it over a valid/ready output handshake.

Parameters:
- WORD_W, 64, input beat width; must divide 512.
- TIMEOUT, 65535, maximum cycles from core launch to core_comp_done before an error is raised.
- TO_W, 16, width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  scheduler accepts a beat
- in_data  in  WORD_W  digest beat
- out_valid  out  1  S result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  256  S result
- busy  out  1  high in every state except LOAD
- err  out  1  sticky watchdog error
- err_clr  in  1  clears err; returns the scheduler to LOAD
- core_ena  out  1  one-cycle start pulse to the S-core
- core_ready  in  1  S-core idle/ready
- core_comp_done  in  1  S-core completion pulse
- hashd_key  out  512  key digest holding register
- hashd_ram  out  512  r digest holding register
- hashd_sm  out  512  message digest holding register
- core_S  in  256  S-core result

Behaviour:
- Reset (rst=0 at a clk edge): state=LOAD, beat counter=0, watchdog=0, in_ready=0 during reset, out_valid=0, out_data=0, err=0, core_ena=0, busy=0, all hashd_* registers=0.
- Beat order is fixed at 24 beats:
  - beats 0–7 fill hashd_key;
  - beats 8–15 fill hashd_ram;
  - beats 16–23 fill hashd_sm.
- Within each operand, beat k writes bits [64k+63:64k] (little-endian words).
- A beat transfers only on a cycle where in_valid and in_ready are both 1.
- LOAD:
  - in_ready=1.
  - The counter increments on each transfer.
  - On transfer of beat 23, the counter wraps to 0 and the state moves to WAIT_RDY on the next edge.
  - in_valid with in_ready=0 is ignored; data is not sampled.
- WAIT_RDY:
  - in_ready=0.
  - When core_ready=1, go to LAUNCH. Otherwise hold; there is no timeout in this state.
- LAUNCH:
  - core_ena=1 for exactly this one cycle.
  - Watchdog clears to 0.
  - Go to RUN.
- RUN:
  - Watchdog increments each cycle.
  - If core_comp_done=1: register core_S into out_data, set out_valid=1, go to OUT. This takes priority over timeout when both occur in the same cycle.
  - Else if watchdog reaches TIMEOUT: err=1, go to ERR.
  - A core_comp_done pulse seen in any other state is ignored.
- OUT:
  - out_valid holds and out_data is stable until out_ready=1.
  - On the handshake cycle, out_valid drops at the next edge and the state returns to LOAD.
  - out_data retains its last value after out_valid falls.
- ERR:
  - in_ready=0, out_valid=0.
  - err_clr=1 clears err and the beat counter and returns to LOAD.
  - err_clr is ignored in all other states.
- hashd_* registers hold their values from the end of LOAD until they are overwritten by the next LOAD. The core sees stable operands for the whole RUN.
- Latency: output is valid 1 cycle after the core_comp_done edge. Best-case input-complete to core_ena is 1 cycle (WAIT_RDY with core_ready already high).
- Reset mid-operation: immediate return to reset values. If reset hits during RUN, any later core_comp_done is ignored because the state is LOAD.
- err_clr and rst both asserted: reset wins.

Test Plan:
- Basic flow: stream 24 beats (key words 0x1..0x8, ram 0x11..0x18, sm 0x21..0x28); core_ready=1; model done 10 cycles after core_ena with core_S=0xA5…A5.
  - Required: hashd_key[63:0]=0x1, hashd_sm[511:448]=0x28.
  - Exactly one core_ena pulse.
  - out_valid one cycle after done, out_data=0xA5…A5.
  - After out_ready: back to LOAD, busy=0.
- Input backpressure: in_valid toggling every other cycle.
  - Registers identical to the previous case; 24 transfers counted.
  - in_ready=0 from WAIT_RDY onward; extra beats are not sampled.
- Core-not-ready stall: core_ready=0 for 50 cycles after load.
  - No core_ena; busy=1.
  - core_ena pulses exactly 1 cycle after core_ready rises.
- Output backpressure: out_ready held 0 for 20 cycles.
  - out_valid and out_data stable throughout; in_ready stays 0; no second core_ena.
- Watchdog: TIMEOUT=100, core never asserts done.
  - err=1 after 100 RUN cycles; out_valid=0.
  - A late done is ignored.
  - err_clr → LOAD, err=0.
  - Same-cycle done and timeout produce a result, not an error.
- Reset mid-RUN: rst=0 for one cycle during RUN.
  - All outputs return to reset values.
  - A later done produces no out_valid.
  - A fresh 24-beat load completes normally.

Source files
------------

// File: rtl/ed25519_sign_s_sched.sv
// Front-end scheduler for the Ed25519 S-core: gathers the key, r and message
// digests from a narrow beat stream, launches the core, guards the run with a
// watchdog and hands the 256-bit S value out over a valid/ready port.
module ed25519_sign_s_sched #(
  parameter int WORD_W  = 64,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [255:0]      out_data,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic              core_ena,
  input  logic              core_ready,
  input  logic              core_comp_done,
  output logic [511:0]      hashd_key,
  output logic [511:0]      hashd_ram,
  output logic [511:0]      hashd_sm,
  input  logic [255:0]      core_S
);

  localparam int BEATS = 512 / WORD_W;
  localparam int TOTAL = 3 * BEATS;
  localparam int CNT_W = $clog2(TOTAL);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    WAIT_RDY = 3'd1,
    LAUNCH   = 3'd2,
    RUN      = 3'd3,
    OUT      = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  wd;
  logic             xfer;
  logic             last_beat;
  logic [1:0]       sel;
  logic [IDX_W-1:0] idx;

  // Beat decode: which digest and which word within it the current beat targets.
  always_comb begin
    xfer      = in_valid && in_ready && (state == LOAD);
    last_beat = (cnt == CNT_W'(TOTAL - 1));
    sel       = 2'd0;
    idx       = '0;
    if (cnt < CNT_W'(BEATS)) begin
      sel = 2'd0;
      idx = IDX_W'(cnt);
    end else if (cnt < CNT_W'(2 * BEATS)) begin
      sel = 2'd1;
      idx = IDX_W'(cnt - CNT_W'(BEATS));
    end else begin
      sel = 2'd2;
      idx = IDX_W'(cnt - CNT_W'(2 * BEATS));
    end
  end

  // Control FSM; all handshake and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      wd        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      core_ena  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      core_ena <= 1'b0;
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (xfer) begin
            if (last_beat) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= WAIT_RDY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_RDY: begin
          // No watchdog here: the core may legitimately stay busy elsewhere.
          if (core_ready) begin
            core_ena <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd    <= '0;
          state <= RUN;
        end
        RUN: begin
          wd <= wd + 1'b1;
          // Completion beats a coincident timeout so a finished result is never lost.
          if (core_comp_done) begin
            out_data  <= core_S;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (wd == TO_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= ERR;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= LOAD;
          end
        end
        ERR: begin
          if (err_clr) begin
            err      <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Digest holding registers: written only by accepted beats, stable otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hashd_key <= '0;
      hashd_ram <= '0;
      hashd_sm  <= '0;
    end else if (xfer) begin
      for (int k = 0; k < BEATS; k++) begin
        if (idx == IDX_W'(k)) begin
          case (sel)
            2'd0:    hashd_key[k*WORD_W +: WORD_W] <= in_data;
            2'd1:    hashd_ram[k*WORD_W +: WORD_W] <= in_data;
            default: hashd_sm[k*WORD_W +: WORD_W]  <= in_data;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ed25519_sign_s_sched.sv
// Directed bench for the Ed25519 S-core scheduler: digest loading, launch,
// result handshake, watchdog error path and mid-run reset.
module tb_ed25519_sign_s_sched;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [63:0]    in_data;
  logic           out_valid;
  logic           out_ready;
  logic [255:0]   out_data;
  logic           busy;
  logic           err;
  logic           err_clr;
  logic           core_ena;
  logic           core_ready;
  logic           core_comp_done;
  logic [511:0]   hashd_key;
  logic [511:0]   hashd_ram;
  logic [511:0]   hashd_sm;
  logic [255:0]   core_S;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int ena_cnt   = 0;

  typedef struct {
    int          op;
    int          word;
    logic [63:0] exp;
  } wvec_t;

  wvec_t tbl [8];

  ed25519_sign_s_sched #(.WORD_W(64), .TIMEOUT(100), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .err_clr(err_clr),
    .core_ena(core_ena), .core_ready(core_ready), .core_comp_done(core_comp_done),
    .hashd_key(hashd_key), .hashd_ram(hashd_ram), .hashd_sm(hashd_sm),
    .core_S(core_S)
  );

  always #5 clk = ~clk;

  // Count launch pulses mid-cycle, away from the edge that changes core_ena.
  always @(negedge clk) if (core_ena) ena_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [63:0] beat_val(input int b);
    if (b < 8)       return 64'(b + 1);
    else if (b < 16) return 64'(32'h11 + b - 8);
    else             return 64'(32'h21 + b - 16);
  endfunction

  function automatic logic [63:0] get_word(input int op, input int word);
    if (op == 0)      return hashd_key[word*64 +: 64];
    else if (op == 1) return hashd_ram[word*64 +: 64];
    else              return hashd_sm[word*64 +: 64];
  endfunction

  task automatic check_table(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_op%0d_w%0d", tag, tbl[i].op, tbl[i].word),
          512'(get_word(tbl[i].op, tbl[i].word)), 512'(tbl[i].exp));
  endtask

  // Stream all 24 beats; with gap set, in_valid idles every other cycle.
  task automatic load_all(input bit gap, input string tag);
    int  b = 0;
    int  cyc = 0;
    bit  x;
    while (b < 24 && cyc < 300) begin
      in_valid = (gap && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      in_data  = beat_val(b);
      x = in_valid && in_ready;
      tick();
      if (x) b++;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_beats"}, 512'(b), 512'(24));
    chk({tag, "_in_ready_after"}, 512'(in_ready), 512'(0));
    chk({tag, "_busy_after"}, 512'(busy), 512'(1));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 512'(out_valid), 512'(0));
    chk({tag, "_busy_idle"}, 512'(busy), 512'(0));
    chk({tag, "_in_ready_idle"}, 512'(in_ready), 512'(1));
  endtask

  initial begin
    logic [255:0] s_val;
    int ena0;
    int bad;

    tbl[0] = '{0, 0, 64'h1};
    tbl[1] = '{0, 4, 64'h5};
    tbl[2] = '{0, 7, 64'h8};
    tbl[3] = '{1, 0, 64'h11};
    tbl[4] = '{1, 3, 64'h14};
    tbl[5] = '{1, 7, 64'h18};
    tbl[6] = '{2, 0, 64'h21};
    tbl[7] = '{2, 7, 64'h28};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    err_clr = 1'b0; core_ready = 1'b0; core_comp_done = 1'b0; core_S = '0;
    tick(); tick();
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_err", 512'(err), 512'(0));
    chk("rst_core_ena", 512'(core_ena), 512'(0));
    chk("rst_out_data", 512'(out_data), 512'(0));
    chk("rst_hashd_key", hashd_key, 512'(0));
    rst = 1'b1;

    // Basic flow: core already ready, done 10 cycles after the launch pulse.
    core_ready = 1'b1;
    ena0 = ena_cnt;
    load_all(1'b0, "basic");
    check_table("basic");
    tick();
    chk("basic_ena_best_case", 512'(core_ena), 512'(1));
    repeat (9) tick();
    chk("basic_no_early_valid", 512'(out_valid), 512'(0));
    s_val = {8{32'hA5A5A5A5}};
    core_comp_done = 1'b1; core_S = s_val;
    tick();
    core_comp_done = 1'b0; core_S = '0;
    chk("basic_out_valid", 512'(out_valid), 512'(1));
    chk("basic_out_data", 512'(out_data), 512'(s_val));
    release_out("basic");
    chk("basic_out_data_kept", 512'(out_data), 512'(s_val));
    chk("basic_ena_count", 512'(ena_cnt - ena0), 512'(1));

    // Input backpressure after a reset, then core-not-ready stall with junk beats.
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rst2_hashd_sm", hashd_sm, 512'(0));
    core_ready = 1'b0;
    load_all(1'b1, "gap");
    check_table("gap");
    ena0 = ena_cnt;
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (50) tick();
    in_valid = 1'b0;
    chk("stall_no_ena", 512'(ena_cnt - ena0), 512'(0));
    chk("stall_busy", 512'(busy), 512'(1));
    chk("stall_in_ready", 512'(in_ready), 512'(0));
    check_table("stall");
    core_ready = 1'b1;
    tick();
    chk("stall_ena_after_ready", 512'(core_ena), 512'(1));

    // Output backpressure: result must hold for 20 cycles.
    repeat (3) tick();
    s_val = {8{32'h3C3C5AA5}};
    core_comp_done = 1'b1; core_S = s_val;
    tick();
    core_comp_done = 1'b0; core_S = '0;
    chk("obp_out_valid", 512'(out_valid), 512'(1));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!out_valid || out_data !== s_val || in_ready) bad++;
    end
    chk("obp_hold_bad_cycles", 512'(bad), 512'(0));
    chk("obp_ena_count", 512'(ena_cnt - ena0), 512'(1));
    release_out("obp");

    // Watchdog expiry, late done ignored, err_clr recovery.
    load_all(1'b0, "wd");
    tick();
    chk("wd_ena", 512'(core_ena), 512'(1));
    repeat (100) tick();
    chk("wd_err_not_yet", 512'(err), 512'(0));
    tick();
    chk("wd_err_set", 512'(err), 512'(1));
    chk("wd_out_valid", 512'(out_valid), 512'(0));
    chk("wd_busy", 512'(busy), 512'(1));
    core_comp_done = 1'b1; core_S = {8{32'h12345678}};
    tick();
    core_comp_done = 1'b0; core_S = '0;
    chk("wd_late_done_ignored", 512'(out_valid), 512'(0));
    chk("wd_err_sticky", 512'(err), 512'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_err_cleared", 512'(err), 512'(0));
    chk("wd_busy_idle", 512'(busy), 512'(0));
    chk("wd_in_ready", 512'(in_ready), 512'(1));

    // Done coincides with the final watchdog cycle: result wins.
    load_all(1'b0, "tie");
    tick();
    repeat (100) tick();
    s_val = {8{32'h77777777}};
    core_comp_done = 1'b1; core_S = s_val;
    tick();
    core_comp_done = 1'b0; core_S = '0;
    chk("tie_out_valid", 512'(out_valid), 512'(1));
    chk("tie_err", 512'(err), 512'(0));
    chk("tie_out_data", 512'(out_data), 512'(s_val));
    release_out("tie");

    // Reset during RUN, stray done afterwards, then a fresh run.
    load_all(1'b0, "mid");
    tick();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_out_valid", 512'(out_valid), 512'(0));
    chk("mid_out_data", 512'(out_data), 512'(0));
    chk("mid_busy", 512'(busy), 512'(0));
    chk("mid_err", 512'(err), 512'(0));
    chk("mid_core_ena", 512'(core_ena), 512'(0));
    chk("mid_in_ready", 512'(in_ready), 512'(0));
    chk("mid_hashd_key", hashd_key, 512'(0));
    tick();
    core_comp_done = 1'b1; core_S = {8{32'hFFFF0000}};
    tick();
    core_comp_done = 1'b0; core_S = '0;
    chk("mid_stray_done", 512'(out_valid), 512'(0));
    chk("mid_stray_busy", 512'(busy), 512'(0));
    ena0 = ena_cnt;
    load_all(1'b0, "fresh");
    check_table("fresh");
    tick();
    chk("fresh_ena", 512'(core_ena), 512'(1));
    repeat (2) tick();
    s_val = {8{32'h0F1E2D3C}};
    core_comp_done = 1'b1; core_S = s_val;
    tick();
    core_comp_done = 1'b0; core_S = '0;
    chk("fresh_out_valid", 512'(out_valid), 512'(1));
    chk("fresh_out_data", 512'(out_data), 512'(s_val));
    release_out("fresh");
    chk("fresh_ena_count", 512'(ena_cnt - ena0), 512'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
